// File: rtl/pulse_meas_pkg.sv
// Shared types and helpers for the pulse rate meter.
package pulse_meas_pkg;

  // Width-measurement FSM: IDLE waits for a synchronized rising edge,
  // MEAS counts high cycles until the falling edge.
  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } meas_state_t;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pulse_rate_meter_if.sv
// Signal bundle between the pulse source/readout side and the meter.
//
// Strobe semantics: count_valid and width_valid are single-cycle strobes with
// no ready/backpressure. The consumer must capture count/count_ovf (resp.
// last_width) in the cycle the strobe is high; the data outputs then hold
// until the next strobe. Both strobes may be high in the same cycle.
interface pulse_rate_meter_if #(
  parameter int CNT_W = 16,
  parameter int WID_W = 8
);
  import pulse_meas_pkg::*;

  logic             pin;
  logic             enable;
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             count_ovf;
  logic [WID_W-1:0] last_width;
  logic             width_valid;
  meas_state_t      dbg_state;

  modport master (
    output pin, enable,
    input  count, count_valid, count_ovf, last_width, width_valid, dbg_state
  );

  modport slave (
    input  pin, enable,
    output count, count_valid, count_ovf, last_width, width_valid, dbg_state
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared to 0 on reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pulse_rate_meter.sv
// Pulse rate meter: synchronizes an asynchronous pulse train, measures each
// pulse width, rejects pulses shorter than MIN_WIDTH and counts accepted
// pulses over a fixed gate window of GATE_CYCLES clocks.
module pulse_rate_meter
  import pulse_meas_pkg::*;
#(
  parameter int GATE_CYCLES = 1000000,
  parameter int CNT_W       = 16,
  parameter int WID_W       = 8,
  parameter int MIN_WIDTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  pulse_rate_meter_if.slave  bus
);

  localparam int                 TMR_W    = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONES = '1;
  localparam logic [WID_W-1:0]   WID_ONES = '1;

  logic             pin_s;
  logic             pin_d_q;
  logic             rise;
  logic             fall;

  meas_state_t      state_q, state_d;
  logic [WID_W-1:0] wcnt_q, wcnt_d;
  logic             accept;

  logic [TMR_W-1:0] timer_q;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] count_q;
  logic             count_valid_q;
  logic             count_ovf_q;
  logic [WID_W-1:0] last_width_q;
  logic             width_valid_q;

  sync_2ff u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (bus.pin),
    .q_o    (pin_s)
  );

  assign rise = pin_s & ~pin_d_q;
  assign fall = ~pin_s & pin_d_q;

  // Edge-detect delay flop, width counter and FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pin_d_q <= 1'b0;
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      pin_d_q <= pin_s;
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Width FSM: start counting on rise, judge the pulse on fall.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    accept  = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = MEAS;
            wcnt_d  = WID_W'(1);
          end
        end
        MEAS: begin
          if (fall) begin
            state_d = IDLE;
            accept  = (32'(wcnt_q) >= MIN_WIDTH);
          end else if (pin_s) begin
            wcnt_d = WID_W'(sat_inc(32'(wcnt_q), 32'(WID_ONES)));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating accept counter; ovf remembers any increment lost at the ceiling.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (accept) begin
      acc_d = CNT_W'(sat_inc(32'(acc_q), 32'(CNT_ONES)));
      ovf_d = ovf_q | (acc_q == CNT_ONES);
    end
  end

  // Latch the width of each accepted pulse with a one-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_width_q  <= '0;
      width_valid_q <= 1'b0;
    end else begin
      width_valid_q <= accept;
      if (accept) begin
        last_width_q <= wcnt_q;
      end
    end
  end

  // Gate timer; on the terminal cycle publish the window result (including a
  // pulse accepted in that same cycle) and restart the accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q       <= '0;
      acc_q         <= '0;
      ovf_q         <= 1'b0;
      count_q       <= '0;
      count_ovf_q   <= 1'b0;
      count_valid_q <= 1'b0;
    end else if (!bus.enable) begin
      timer_q       <= '0;
      acc_q         <= '0;
      ovf_q         <= 1'b0;
      count_valid_q <= 1'b0;
    end else if (timer_q == TMR_LAST) begin
      timer_q       <= '0;
      acc_q         <= '0;
      ovf_q         <= 1'b0;
      count_q       <= acc_d;
      count_ovf_q   <= ovf_d;
      count_valid_q <= 1'b1;
    end else begin
      timer_q       <= timer_q + TMR_W'(1);
      acc_q         <= acc_d;
      ovf_q         <= ovf_d;
      count_valid_q <= 1'b0;
    end
  end

  assign bus.count       = count_q;
  assign bus.count_valid = count_valid_q;
  assign bus.count_ovf   = count_ovf_q;
  assign bus.last_width  = last_width_q;
  assign bus.width_valid = width_valid_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Directed bench for pulse_rate_meter. Three instances share clk, rst and pin:
//   A: GATE_CYCLES=100,  CNT_W=16  (basic counting, rejection, window edge, reset)
//   B: GATE_CYCLES=300,  CNT_W=4   (count saturation; 300 so 20 pulses fit one window)
//   C: GATE_CYCLES=1000, CNT_W=16  (width saturation, enable-low hold)
// Only one instance is enabled at a time.
module tb_pulse_rate_meter;
  import pulse_meas_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic pin  = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic en_c = 1'b0;

  pulse_rate_meter_if #(.CNT_W(16), .WID_W(8)) a_if ();
  pulse_rate_meter_if #(.CNT_W(4),  .WID_W(8)) b_if ();
  pulse_rate_meter_if #(.CNT_W(16), .WID_W(8)) c_if ();

  assign a_if.pin = pin;
  assign b_if.pin = pin;
  assign c_if.pin = pin;
  assign a_if.enable = en_a;
  assign b_if.enable = en_b;
  assign c_if.enable = en_c;

  pulse_rate_meter #(.GATE_CYCLES(100), .CNT_W(16), .WID_W(8), .MIN_WIDTH(4)) u_a (
    .clk(clk), .rst(rst), .bus(a_if.slave));
  pulse_rate_meter #(.GATE_CYCLES(300), .CNT_W(4), .WID_W(8), .MIN_WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .bus(b_if.slave));
  pulse_rate_meter #(.GATE_CYCLES(1000), .CNT_W(16), .WID_W(8), .MIN_WIDTH(4)) u_c (
    .clk(clk), .rst(rst), .bus(c_if.slave));

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int wv_a = 0;
  int wv_b = 0;
  int wv_c = 0;
  // Window results as {ovf, count[15:0]}, pushed when count_valid is seen.
  logic [16:0] a_q[$];
  logic [16:0] b_q[$];
  logic [16:0] c_q[$];
  logic [16:0] w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance n cycles; sample outputs 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (a_if.width_valid) wv_a++;
      if (b_if.width_valid) wv_b++;
      if (c_if.width_valid) wv_c++;
      if (a_if.count_valid) a_q.push_back({a_if.count_ovf, a_if.count});
      if (b_if.count_valid) b_q.push_back({b_if.count_ovf, 12'd0, b_if.count});
      if (c_if.count_valid) c_q.push_back({c_if.count_ovf, c_if.count});
    end
  endtask

  task automatic pulse(input int width, input int gap);
    pin = 1'b1;
    step(width);
    pin = 1'b0;
    step(gap);
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return a_q.size();
      1:       return b_q.size();
      default: return c_q.size();
    endcase
  endfunction

  function automatic logic [16:0] pop_win(input int which);
    logic [16:0] r;
    r = '1;
    case (which)
      0:       if (a_q.size() != 0) r = a_q.pop_front();
      1:       if (b_q.size() != 0) r = b_q.pop_front();
      default: if (c_q.size() != 0) r = c_q.pop_front();
    endcase
    return r;
  endfunction

  // Wait (bounded) for the next window result of one instance.
  task automatic wait_win(input int which, input int budget, input string tag);
    int k;
    k = 0;
    while (qsize(which) == 0 && k < budget) begin
      step(1);
      k++;
    end
    check({tag, " strobe"}, 32'(qsize(which) != 0), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    step(3);
    check("rst count",       32'(a_if.count), 32'd0);
    check("rst count_valid", 32'(a_if.count_valid), 32'd0);
    check("rst count_ovf",   32'(a_if.count_ovf), 32'd0);
    check("rst last_width",  32'(a_if.last_width), 32'd0);
    check("rst width_valid", 32'(a_if.width_valid), 32'd0);
    check("rst state",       32'(a_if.dbg_state), 32'(IDLE));
    rst = 1'b1;
    step(2);

    // 1: three 31-cycle pulses; the last falls in the terminal cycle
    en_a = 1'b1;
    pulse(31, 2);
    pulse(31, 2);
    pulse(31, 2);
    check("t1 no strobe before 100", 32'(a_q.size()), 32'd0);
    step(1);
    check("t1 strobe at 100", 32'(a_q.size()), 32'd1);
    w = pop_win(0);
    check("t1 count", 32'(w[15:0]), 32'd3);
    check("t1 ovf",   32'(w[16]), 32'd0);
    step(1);
    check("t1 strobe single", 32'(a_q.size()), 32'd0);
    step(2);
    check("t1 width strobes", 32'(wv_a), 32'd3);
    check("t1 last_width",    32'(a_if.last_width), 32'd31);

    // 2: 3-cycle pulse dropped, 4-cycle pulse accepted
    wv_a = 0;
    pulse(3, 8);
    check("t2 short no strobe", 32'(wv_a), 32'd0);
    check("t2 short width hold", 32'(a_if.last_width), 32'd31);
    pulse(4, 8);
    check("t2 min strobe", 32'(wv_a), 32'd1);
    check("t2 min width",  32'(a_if.last_width), 32'd4);
    wait_win(0, 200, "t2");
    w = pop_win(0);
    check("t2 count", 32'(w[15:0]), 32'd1);
    check("t2 ovf",   32'(w[16]), 32'd0);

    // 4: pulse straddling window end counts in the window of its fall
    step(95);
    pin = 1'b1;
    step(10);
    pin = 1'b0;
    wait_win(0, 300, "t4 w1");
    w = pop_win(0);
    check("t4 w1 count", 32'(w[15:0]), 32'd0);
    wait_win(0, 300, "t4 w2");
    w = pop_win(0);
    check("t4 w2 count", 32'(w[15:0]), 32'd1);
    check("t4 last_width", 32'(a_if.last_width), 32'd10);

    // 6: asynchronous reset mid-pulse at window cycle 50
    step(40);
    pin = 1'b1;
    step(10);
    rst = 1'b0;
    #1;
    check("t6 count",       32'(a_if.count), 32'd0);
    check("t6 count_valid", 32'(a_if.count_valid), 32'd0);
    check("t6 count_ovf",   32'(a_if.count_ovf), 32'd0);
    check("t6 last_width",  32'(a_if.last_width), 32'd0);
    check("t6 width_valid", 32'(a_if.width_valid), 32'd0);
    check("t6 state",       32'(a_if.dbg_state), 32'(IDLE));
    step(3);
    pin = 1'b0;
    step(3);
    rst = 1'b1;
    a_q.delete();
    wv_a = 0;
    pulse(10, 10);
    pulse(10, 10);
    step(59);
    check("t6 no strobe before 100", 32'(a_q.size()), 32'd0);
    step(1);
    check("t6 strobe at 100", 32'(a_q.size()), 32'd1);
    w = pop_win(0);
    check("t6 count", 32'(w[15:0]), 32'd2);
    check("t6 ovf",   32'(w[16]), 32'd0);
    check("t6 width strobes", 32'(wv_a), 32'd2);
    en_a = 1'b0;
    step(2);

    // 3: CNT_W=4 saturation, then an empty window clears it
    en_b = 1'b1;
    for (int i = 0; i < 20; i++) pulse(5, 5);
    wait_win(1, 400, "t3 w1");
    w = pop_win(1);
    check("t3 w1 count", 32'(w[15:0]), 32'd15);
    check("t3 w1 ovf",   32'(w[16]), 32'd1);
    check("t3 width strobes", 32'(wv_b), 32'd20);
    wait_win(1, 400, "t3 w2");
    w = pop_win(1);
    check("t3 w2 count", 32'(w[15:0]), 32'd0);
    check("t3 w2 ovf",   32'(w[16]), 32'd0);

    // Pulse already high when enable rises is not counted
    en_b = 1'b0;
    wv_b = 0;
    pin = 1'b1;
    step(5);
    en_b = 1'b1;
    step(10);
    pin = 1'b0;
    wait_win(1, 400, "pre-high");
    w = pop_win(1);
    check("pre-high count", 32'(w[15:0]), 32'd0);
    check("pre-high width strobes", 32'(wv_b), 32'd0);
    en_b = 1'b0;
    step(2);

    // 5: 300-cycle pulse saturates the width at 255
    en_c = 1'b1;
    pulse(300, 10);
    check("t5 width strobes", 32'(wv_c), 32'd1);
    check("t5 last_width",    32'(c_if.last_width), 32'd255);
    wait_win(2, 1200, "t5");
    w = pop_win(2);
    check("t5 count", 32'(w[15:0]), 32'd1);

    // enable=0: results hold, no strobes, pulses ignored
    en_c = 1'b0;
    pulse(10, 1190);
    check("hold no count strobe", 32'(c_q.size()), 32'd0);
    check("hold no width strobe", 32'(wv_c), 32'd1);
    check("hold count",      32'(c_if.count), 32'd1);
    check("hold last_width", 32'(c_if.last_width), 32'd255);
    check("hold state",      32'(c_if.dbg_state), 32'(IDLE));

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
